// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped board-input block.
// Holds the IO word layout, the default debounce length and the
// load/store-unit decode addresses for the key and switch registers.
package io_pkg;

    localparam int unsigned IO_WORD_W         = 32;
    localparam int unsigned KEY_LEVEL_LSB     = 0;
    localparam int unsigned KEY_FLAG_LSB      = 8;
    localparam int unsigned CLR_MASK_W        = 8;
    localparam int unsigned DB_CYCLES_DEFAULT = 500000;

    localparam logic [31:0] SW_REG_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] KEY_REG_ADDR = 32'hFFFF_0010;

endpackage

// File: rtl/io_input_conditioner_if.sv
// Load/store-unit side of the input conditioner.
//   clr_en_i      one-cycle store strobe to the key register
//   clr_mask_i    store data [7:0], bit k = 1 clears sticky flag k
//   press_pulse_o one-cycle pulse per accepted key press
//   io_key_o      debounced key levels [7:0], sticky flags [15:8]
//   io_sw_o       conditioned switches
// slave: the conditioner; master: the load/store unit.
interface io_input_conditioner_if #(
    parameter int unsigned NUM_KEYS = 4
) ();
    import io_pkg::*;

    logic                  clr_en_i;
    logic [CLR_MASK_W-1:0] clr_mask_i;
    logic [NUM_KEYS-1:0]   press_pulse_o;
    logic [IO_WORD_W-1:0]  io_key_o;
    logic [IO_WORD_W-1:0]  io_sw_o;

    modport slave (
        input  clr_en_i,
        input  clr_mask_i,
        output press_pulse_o,
        output io_key_o,
        output io_sw_o
    );

    modport master (
        output clr_en_i,
        output clr_mask_i,
        input  press_pulse_o,
        input  io_key_o,
        input  io_sw_o
    );

endinterface

// File: rtl/debounce_cell.sv
// Two-flop synchroniser plus counter-based debouncer for one input bit.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   d_i            raw asynchronous input (already in "1 = active" sense)
//   q_o            accepted stable level, reset to RST_VAL
//   rise_o         one-cycle pulse in the cycle q_o first reads 1
// A new level is accepted after DB_CYCLES consecutive cycles of the
// synchronised input disagreeing with q_o; any agreement restarts the count.
module debounce_cell #(
    parameter int unsigned DB_CYCLES = io_pkg::DB_CYCLES_DEFAULT,
    parameter logic        RST_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchroniser, saturating counter and stable-level commit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            cnt_q   <= '0;
            q_o     <= RST_VAL;
            rise_o  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            rise_o  <= 1'b0;
            if (sync2_q == q_o) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                q_o    <= sync2_q;
                cnt_q  <= '0;
                rise_o <= sync2_q;
            end
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Board-input stage feeding the RV32I load/store unit.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   key_raw_ni     raw push keys, 0 = pressed
//   sw_raw_i       raw slide switches
//   bus            io_input_conditioner_if.slave (clear strobe in;
//                  press pulses, io_key word, io_sw word out)
// Build option: define SW_DEBOUNCE_EN to debounce the switches with the
// same cell as the keys; otherwise switches are only synchronised.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned NUM_KEYS  = 4,
    parameter int unsigned NUM_SW    = 18,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_KEYS-1:0]   key_raw_ni,
    input  logic [NUM_SW-1:0]     sw_raw_i,
    io_input_conditioner_if.slave bus
);

    logic [NUM_KEYS-1:0]  key_level;
    logic [NUM_KEYS-1:0]  key_rise;
    logic [NUM_KEYS-1:0]  press_pulse_q;
    logic [NUM_KEYS-1:0]  flag_q;
    logic [NUM_KEYS-1:0]  clr_keys;
    logic [IO_WORD_W-1:0] key_word;
    logic                 clr_mask_unused;
    logic [NUM_SW-1:0]    sw_cond;
    logic [NUM_SW-1:0]    sw_q;

    // Keys are inverted ahead of the cell so that 1 = pressed internally
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (1'b0)
        ) u_db (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (~key_raw_ni[k]),
            .q_o    (key_level[k]),
            .rise_o (key_rise[k])
        );
    end

    // Mask bits above NUM_KEYS have no flag to clear
    assign clr_keys        = bus.clr_en_i ? bus.clr_mask_i[NUM_KEYS-1:0] : '0;
    assign clr_mask_unused = ^bus.clr_mask_i;

    // Press pulse register and sticky flags; a same-cycle set beats the clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            press_pulse_q <= '0;
            flag_q        <= '0;
        end else begin
            press_pulse_q <= key_rise;
            flag_q        <= (flag_q & ~clr_keys) | press_pulse_q;
        end
    end

    // Key word is pure wiring of flop outputs
    always_comb begin
        key_word                                = '0;
        key_word[KEY_LEVEL_LSB +: NUM_KEYS]     = key_level;
        key_word[KEY_FLAG_LSB +: NUM_KEYS]      = flag_q;
    end

`ifdef SW_DEBOUNCE_EN
    logic [NUM_SW-1:0] sw_rise_unused;

    for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (1'b0)
        ) u_db (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (sw_raw_i[s]),
            .q_o    (sw_cond[s]),
            .rise_o (sw_rise_unused[s])
        );
    end
`else
    logic [NUM_SW-1:0] sw_sync1_q;
    logic [NUM_SW-1:0] sw_sync2_q;

    // Plain two-flop synchroniser for the switches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= sw_raw_i;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    assign sw_cond = sw_sync2_q;
`endif

    // Switch output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_q <= '0;
        end else begin
            sw_q <= sw_cond;
        end
    end

    assign bus.press_pulse_o = press_pulse_q;
    assign bus.io_key_o      = key_word;
    assign bus.io_sw_o       = IO_WORD_W'(sw_q);

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner (DB_CYCLES = 8).
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and
// compares them, and separately matches every press pulse against a queue.
module tb_io_input_conditioner;
    import io_pkg::*;

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned NUM_SW   = 18;
    localparam int unsigned DB       = 8;
`ifdef SW_DEBOUNCE_EN
    localparam int SW_LAT   = 3 + DB;
    localparam bit SW_DEB   = 1'b1;
`else
    localparam int SW_LAT   = 3;
    localparam bit SW_DEB   = 1'b0;
`endif

    typedef enum int {F_KEY, F_SW, F_PULSE} field_e;

    typedef struct {
        int          at_cyc;
        field_e      field;
        logic [31:0] mask;
        logic [31:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        int                  at_cyc;
        logic [NUM_KEYS-1:0] val;
    } pulse_t;

    chk_t   chk_q[$];
    pulse_t pulse_q[$];
    int     cyc      = 0;
    int     checks   = 0;
    int     failures = 0;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic [NUM_KEYS-1:0] key_raw_n = '0;
    logic [NUM_SW-1:0]   sw_raw    = '0;

    io_input_conditioner_if #(.NUM_KEYS(NUM_KEYS)) bus ();

    io_input_conditioner #(
        .NUM_KEYS  (NUM_KEYS),
        .NUM_SW    (NUM_SW),
        .DB_CYCLES (DB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .key_raw_ni (key_raw_n),
        .sw_raw_i   (sw_raw),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] field_val(field_e f);
        case (f)
            F_KEY:   return bus.io_key_o;
            F_SW:    return bus.io_sw_o;
            default: return 32'(bus.press_pulse_o);
        endcase
    endfunction

    task automatic expect_at(input int d, input field_e f, input logic [31:0] m,
                             input logic [31:0] e, input string n);
        chk_q.push_back('{cyc + d, f, m, e, n});
    endtask

    task automatic expect_pulse(input int d, input logic [NUM_KEYS-1:0] v);
        pulse_q.push_back('{cyc + d, v});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: level checks due this cycle, then press-pulse scoreboard
    always @(negedge clk) begin
        logic [31:0] act;
        pulse_t      p;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].at_cyc == cyc) begin
                act = field_val(chk_q[i].field) & chk_q[i].mask;
                checks++;
                if (act !== chk_q[i].exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h",
                             chk_q[i].name, cyc, act, chk_q[i].exp);
                end
                chk_q.delete(i);
            end
        end
        while (pulse_q.size() > 0 && pulse_q[0].at_cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL pulse_missing cyc=%0d actual=none required=%h at cyc %0d",
                     cyc, pulse_q[0].val, pulse_q[0].at_cyc);
            void'(pulse_q.pop_front());
        end
        if (bus.press_pulse_o !== '0) begin
            checks++;
            if (pulse_q.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected cyc=%0d actual=%h required=none",
                         cyc, bus.press_pulse_o);
            end else begin
                p = pulse_q.pop_front();
                if (p.at_cyc != cyc || p.val !== bus.press_pulse_o) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d actual=%h required=%h at cyc %0d",
                             cyc, bus.press_pulse_o, p.val, p.at_cyc);
                end
            end
        end
    end

    initial begin
        bus.clr_en_i   = 1'b0;
        bus.clr_mask_i = 8'h00;

        // Reset with all keys held
        step(2);
        expect_at(0, F_KEY,   32'hFFFF_FFFF, 32'h0, "rst_key");
        expect_at(0, F_SW,    32'hFFFF_FFFF, 32'h0, "rst_sw");
        expect_at(0, F_PULSE, 32'hFFFF_FFFF, 32'h0, "rst_pulse");
        step(1);
        rst_n = 1'b1;
        expect_at(9,  F_KEY, 32'h0000_000F, 32'h0,   "rst_hold_early");
        expect_at(10, F_KEY, 32'h0000_000F, 32'hF,   "rst_hold_level");
        expect_pulse(11, 4'hF);
        expect_at(11, F_KEY, 32'h0000_0F00, 32'h0,   "rst_hold_flag_early");
        expect_at(12, F_KEY, 32'h0000_0F00, 32'hF00, "rst_hold_flag");
        step(14);

        // Release all keys: level drops, no pulse, flags stay
        key_raw_n = 4'hF;
        expect_at(9,  F_KEY, 32'h0000_000F, 32'hF,   "release_early");
        expect_at(10, F_KEY, 32'h0000_0F0F, 32'hF00, "release_level");
        step(12);

        // Clear everything, including mask bits above NUM_KEYS
        bus.clr_en_i   = 1'b1;
        bus.clr_mask_i = 8'hFF;
        expect_at(1, F_KEY, 32'hFFFF_FFFF, 32'h0, "clear_all");
        step(1);
        bus.clr_en_i = 1'b0;
        step(1);

        // Clean press of key1
        key_raw_n = 4'b1101;
        expect_at(9,  F_KEY, 32'h0000_0002, 32'h0,   "press1_early");
        expect_at(10, F_KEY, 32'h0000_0002, 32'h2,   "press1_level");
        expect_pulse(11, 4'h2);
        expect_at(11, F_KEY, 32'h0000_0200, 32'h0,   "press1_flag_early");
        expect_at(12, F_KEY, 32'h0000_0200, 32'h200, "press1_flag");
        expect_at(20, F_KEY, 32'h0000_0F0F, 32'h202, "press1_hold");
        step(21);

        // Bouncing key0: low 5, high 1, then low steady
        key_raw_n = 4'b1100;
        expect_at(5, F_KEY, 32'h0000_0001, 32'h0, "bounce_mid");
        step(5);
        key_raw_n = 4'b1101;
        step(1);
        key_raw_n = 4'b1100;
        expect_at(2,  F_KEY, 32'h0000_0001, 32'h0,   "bounce_restart");
        expect_at(9,  F_KEY, 32'h0000_0001, 32'h0,   "bounce_early");
        expect_at(10, F_KEY, 32'h0000_0001, 32'h1,   "bounce_level");
        expect_pulse(11, 4'h1);
        expect_at(12, F_KEY, 32'h0000_0F0F, 32'h303, "bounce_flags");
        step(13);

        // Key2 press with a clear landing on the pulse cycle
        key_raw_n = 4'b1000;
        expect_pulse(11, 4'h4);
        step(11);
        bus.clr_en_i   = 1'b1;
        bus.clr_mask_i = 8'h0F;
        expect_at(1, F_KEY, 32'h0000_0F00, 32'h400, "race_set_wins");
        step(1);
        bus.clr_mask_i = 8'hF0;
        expect_at(1, F_KEY, 32'h0000_0F00, 32'h400, "clear_high_ignored");
        step(1);
        bus.clr_mask_i = 8'h0F;
        expect_at(1, F_KEY, 32'h0000_0F0F, 32'h007, "clear_alone");
        step(1);
        bus.clr_en_i = 1'b0;
        step(2);

        // Switch latency
        sw_raw = 18'h2A5A5;
        expect_at(SW_LAT - 1, F_SW, 32'hFFFF_FFFF, 32'h0,       "sw_early");
        expect_at(SW_LAT,     F_SW, 32'hFFFF_FFFF, 32'h0002A5A5, "sw_value");
        step(SW_LAT + 2);

        // Three-cycle switch glitch
        sw_raw = 18'h0;
        expect_at(3,  F_SW, 32'hFFFF_FFFF, SW_DEB ? 32'h0002A5A5 : 32'h0, "sw_glitch");
        expect_at(6,  F_SW, 32'hFFFF_FFFF, 32'h0002A5A5, "sw_glitch_after");
        expect_at(14, F_SW, 32'hFFFF_FFFF, 32'h0002A5A5, "sw_glitch_settled");
        step(3);
        sw_raw = 18'h2A5A5;
        step(12);

        // Key3 press interrupted by reset at count 5
        key_raw_n = 4'b0000;
        step(7);
        rst_n = 1'b0;
        expect_at(0, F_KEY, 32'hFFFF_FFFF, 32'h0, "midrst_key");
        expect_at(0, F_SW,  32'hFFFF_FFFF, 32'h0, "midrst_sw");
        step(1);
        rst_n = 1'b1;
        expect_at(9,  F_KEY, 32'h0000_0008, 32'h0, "midrst_early");
        expect_at(10, F_KEY, 32'h0000_000F, 32'hF, "midrst_level");
        expect_pulse(11, 4'hF);
        expect_at(12, F_KEY, 32'h0000_0F0F, 32'hF0F, "midrst_flags");
        step(16);

        foreach (chk_q[i]) begin
            checks++;
            failures++;
            $display("FAIL %s_never_checked actual=none required=%h", chk_q[i].name, chk_q[i].exp);
        end
        foreach (pulse_q[i]) begin
            checks++;
            failures++;
            $display("FAIL pulse_never_seen actual=none required=%h", pulse_q[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
